// File: rtl/reset_sync.sv
//------------------------------------------------------------------------------
// reset_sync
//
// Reset synchronizer for the chip-level pad reset. Every other TinyBF block
// takes sync_rst_o as its system reset.
//
// The reset asserts asynchronously: sync_rst_o drops as soon as async_rst_i
// drops, and no clock is needed. The reset releases synchronously: a 1 walks
// through a chain of STAGES flops, so sync_rst_o rises on exactly the
// STAGES-th rising edge of clk_i after the release. The extra flops give a
// metastable first stage time to resolve.
//
// Ports:
//   clk_i        in   1  system clock; the chain shifts on the rising edge
//   async_rst_i  in   1  active-low reset request from the pad, any phase
//   sync_rst_o   out  1  active-low system reset, taken straight from the
//                        last chain flop
//
// Parameters:
//   STAGES       number of chain flops, which is also the release latency in
//                clock edges. The legal range is 2..8.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module reset_sync #(
   parameter int STAGES = 3
) (
   input  logic clk_i,
   input  logic async_rst_i,
   output logic sync_rst_o
);

   // A single flop cannot give a metastable sample time to settle, and a very
   // deep chain only adds release latency.
   if (STAGES < 2) begin : g_stages_too_small
      $error("reset_sync: STAGES must be at least 2");
   end
   if (STAGES > 8) begin : g_stages_too_large
      $error("reset_sync: STAGES must be at most 8");
   end

   // Benches probe this chain by its hierarchical name. The attributes keep
   // the flops packed together as a synchronizer and keep them out of
   // retiming.
   (* ASYNC_REG = "TRUE", dont_retime = "true" *)
   logic [STAGES-1:0] reset_sync_chain;
   logic [STAGES-1:0] reset_sync_chain_d;

   // Next chain value: a 1 is shifted in at bit 0 and moves toward the output.
   always_comb begin
      reset_sync_chain_d = {reset_sync_chain[STAGES-2:0], 1'b1};
   end

   // Chain flops: cleared asynchronously by the pad reset and never set, so
   // the assertion reaches the output without waiting for a clock.
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         reset_sync_chain <= {STAGES{1'b0}};
      end else begin
         reset_sync_chain <= reset_sync_chain_d;
      end
   end

   // The last flop drives the output directly, with no combinational logic
   // after it.
   assign sync_rst_o = reset_sync_chain[STAGES-1];

endmodule

// File: tb/tb_reset_sync.sv
`timescale 1ns/1ps

module tb_reset_sync;

   localparam int STAGES = 3;
   localparam int T      = 20;

   logic clk_i       = 1'b0;
   logic async_rst_i = 1'b1;
   logic sync_rst_o;

   int total = 0;
   int bad   = 0;

   // Reference model: the number of rising edges seen since the last release.
   int rel_edges = 0;
   bit model_en  = 1'b0;

   reset_sync #(.STAGES(STAGES)) dut (
      .clk_i       (clk_i),
      .async_rst_i (async_rst_i),
      .sync_rst_o  (sync_rst_o)
   );

   // Clock with period T; the rising edges fall at 10, 30, 50 ns and so on.
   initial forever #(T/2) clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // The output is high once at least STAGES edges have passed since the release.
   function automatic logic exp_out(input int e, input logic a);
      return a && (e >= STAGES);
   endfunction

   // The chain holds one 1 for each edge since the release, up to STAGES of them.
   function automatic logic [31:0] exp_chain(input int e, input logic a);
      int n;
      if (!a) return 32'd0;
      n = (e > STAGES) ? STAGES : e;
      return (32'd1 << n) - 32'd1;
   endfunction

   // Any drop of the pad reset restarts the release count.
   always @(negedge async_rst_i) rel_edges = 0;

   // Each rising edge with the pad reset released adds one to the count.
   always @(posedge clk_i) if (async_rst_i === 1'b1 && rel_edges < 100000) rel_edges = rel_edges + 1;

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk_i) begin
      if (model_en) begin
         check_val("model_out", {31'd0, sync_rst_o}, {31'd0, exp_out(rel_edges, async_rst_i)});
         check_val("model_chain", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, exp_chain(rel_edges, async_rst_i));
      end
   end

   initial begin
      bit done;
      int d;

      // Power-up: pulse the pad reset once so the chain holds a known value.
      #2 async_rst_i = 1'b0;
      #1 check_val("reset_out", {31'd0, sync_rst_o}, 32'd0);
      check_val("reset_chain", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, 32'd0);
      model_en = 1'b1;
      repeat (3) @(posedge clk_i);

      // Stage count: release T/4 after a falling edge, then sample after each rising edge.
      @(negedge clk_i); #(T/4) async_rst_i = 1'b1;
      for (int k = 1; k <= STAGES; k++) begin
         @(posedge clk_i); #1;
         check_val("stage_out", {31'd0, sync_rst_o}, (k >= STAGES) ? 32'd1 : 32'd0);
         check_val("stage_chain", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, (32'd1 << k) - 32'd1);
      end

      // Async assert: drop the pad reset T/3 after a rising edge; no edge before the check.
      repeat (5) @(posedge clk_i);
      #(T/3) async_rst_i = 1'b0;
      #1 check_val("async_assert_out", {31'd0, sync_rst_o}, 32'd0);
      check_val("async_assert_chain", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, 32'd0);

      // Held low: after a release at an odd time, the output is still low at the next edge.
      @(posedge clk_i); #7 async_rst_i = 1'b1;
      @(posedge clk_i); #1 check_val("release_next_edge", {31'd0, sync_rst_o}, 32'd0);
      repeat (4) @(posedge clk_i);

      // Long assertion for 100 clocks, checked continuously by the model.
      #3 async_rst_i = 1'b0;
      repeat (100) @(posedge clk_i);
      #4 async_rst_i = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 5 && !done; i++) begin
         @(posedge clk_i); #1;
         if (sync_rst_o === 1'b1) done = 1'b1;
      end
      check_val("long_release_within_5", {31'd0, sync_rst_o}, 32'd1);

      // Phase sweep: a release exactly on an edge has no single defined outcome,
      // so only the final output is checked here.
      model_en = 1'b0;
      for (int p = 0; p < 4; p++) begin
         async_rst_i = 1'b0;
         repeat (2) @(posedge clk_i);
         if (p != 0) #(p * 5);
         async_rst_i = 1'b1;
         repeat (STAGES + 2) @(posedge clk_i);
         #1 check_val("phase_sweep", {31'd0, sync_rst_o}, 32'd1);
      end
      repeat (2) @(negedge clk_i);
      model_en = 1'b1;

      // Glitch: a 2 ns low pulse gives a full STAGES-edge release.
      @(posedge clk_i); #5 async_rst_i = 1'b0;
      #1 check_val("glitch_low", {31'd0, sync_rst_o}, 32'd0);
      #1 async_rst_i = 1'b1;
      for (int k = 1; k <= STAGES; k++) begin
         @(posedge clk_i); #1;
         check_val("glitch_release", {31'd0, sync_rst_o}, (k >= STAGES) ? 32'd1 : 32'd0);
      end

      // Three 2-clock pulses, each followed by a 5-clock wait.
      for (int r = 0; r < 3; r++) begin
         @(negedge clk_i); #3 async_rst_i = 1'b0;
         repeat (2) @(posedge clk_i);
         #3 async_rst_i = 1'b1;
         repeat (5) @(posedge clk_i);
         #1 check_val("pulse_repeat", {31'd0, sync_rst_o}, 32'd1);
      end

      // Re-assert after one edge of the release, then release again.
      async_rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i); #3 async_rst_i = 1'b1;
      @(posedge clk_i); #1 check_val("mid_chain_one", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, 32'd1);
      #3 async_rst_i = 1'b0;
      #1 check_val("mid_reassert_chain", {{(32-STAGES){1'b0}}, dut.reset_sync_chain}, 32'd0);
      check_val("mid_reassert_out", {31'd0, sync_rst_o}, 32'd0);
      @(negedge clk_i); #3 async_rst_i = 1'b1;
      for (int k = 1; k <= STAGES; k++) begin
         @(posedge clk_i); #1;
         check_val("mid_rerelease", {31'd0, sync_rst_o}, (k >= STAGES) ? 32'd1 : 32'd0);
      end

      // Random toggling at random times that never land on a clock edge.
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(1, 80));
         #d;
         if (($time % 10) == 0) #1;
         async_rst_i = ~async_rst_i;
      end
      #3 async_rst_i = 1'b1;
      repeat (STAGES + 2) @(posedge clk_i);
      #1 check_val("random_final", {31'd0, sync_rst_o}, 32'd1);

      model_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
